fifo_sync_param: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's FIFO block: configurable data width and depth, programmable almost-full/almost-empty thresholds, occupancy count and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain. It is the RTL target of the existing layered FIFO testbench once that bench is extended for threshold and error checking.

---
 rtl/fifo_rtl_pkg.sv | 23 ++
 rtl/fifo_ram.sv | 39 +++
 rtl/fifo_sync_param.sv | 144 ++++++++++++++
 tb/tb_fifo_sync_param.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_rtl_pkg.sv
// Shared types and constants for the fifo_sync_param block and its bench.
// Build option FIFO_FWFT_EN (first-word fall-through) is consumed by fifo_ram and fifo_sync_param.
package fifo_rtl_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 16;

    // Pointer/count width for a given depth: address bits plus one wrap bit.
    function automatic int unsigned ptr_bits(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [ptr_bits(DEFAULT_DEPTH)-1:0] ptr_t;
    typedef logic [ptr_bits(DEFAULT_DEPTH)-1:0] cnt_t;

    typedef enum logic [0:0] {
        ERR_OVERFLOW  = 1'b0,
        ERR_UNDERFLOW = 1'b1
    } err_e;

    localparam int unsigned NUM_ERR = 2;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH simple dual-port storage: synchronous write, read port
// registered by default or combinational when FIFO_FWFT_EN is defined.
module fifo_ram
    import fifo_rtl_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned  DEPTH      = DEFAULT_DEPTH,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
`ifndef FIFO_FWFT_EN
    input  logic                  rd_en,
`endif
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data = mem[rd_addr];
`else
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is registered reads.
module fifo_sync_param
    import fifo_rtl_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned  DEPTH      = DEFAULT_DEPTH,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic [AW:0]           af_thresh,
    input  logic [AW:0]           ae_thresh,
    input  logic                  clr_err,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PW         = ptr_bits(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         occupancy;
    logic [NUM_ERR-1:0]    err_q;
    logic [NUM_ERR-1:0]    err_d;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_evt;
    logic                  udf_evt;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign full         = (count == FULL_COUNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);
    assign overflow     = err_q[ERR_OVERFLOW];
    assign underflow    = err_q[ERR_UNDERFLOW];
    assign occupancy    = wr_ptr - rd_ptr;

    // Acceptance uses the registered flags, so at full only the read goes and at empty only the write.
    always_comb begin
        wr_acc  = wr_en && !full;
        rd_acc  = rd_en && !empty;
        ovf_evt = wr_en && full;
        udf_evt = rd_en && empty;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + (AW + 1)'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        err_d = clr_err ? '0 : err_q;
        if (ovf_evt) begin
            err_d[ERR_OVERFLOW] = 1'b1;
        end
        if (udf_evt) begin
            err_d[ERR_UNDERFLOW] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (occupancy == count);
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc && rst_n),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
`ifndef FIFO_FWFT_EN
        .rd_en   (rd_acc),
`endif
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_rd_data)
    );

`ifdef FIFO_FWFT_EN
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : ram_rd_data;
`else
    logic rd_valid_q;
    logic rd_seen;

    // The RAM read register has no reset; rd_seen masks it to zero until the first read after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_seen    <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_seen <= 1'b1;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_seen ? ram_rd_data : '0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param with a queue scoreboard and a count/flag model.
module tb_fifo_sync_param;
    import fifo_rtl_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 16;
    localparam int unsigned AW  = $clog2(DEP);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;
    logic          clr_err;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;

    fifo_sync_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .clr_err      (clr_err),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb[$];
    int            m_count   = 0;
    logic          m_err[2]  = '{1'b0, 1'b0};
    logic [DW-1:0] m_rd_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, predict, then compare every output #1 after the edge.
    task automatic cycle(input logic rst, input logic wen, input logic [DW-1:0] wd,
                         input logic ren, input logic clr);
        logic wacc, racc, ovf_ev, udf_ev;
        rst_n   = !rst;
        wr_en   = wen;
        wr_data = wd;
        rd_en   = ren;
        clr_err = clr;
        wacc   = !rst && wen && (m_count != int'(DEP));
        racc   = !rst && ren && (m_count != 0);
        ovf_ev = !rst && wen && (m_count == int'(DEP));
        udf_ev = !rst && ren && (m_count == 0);
        if (wacc) sb.push_back(wd);
        @(posedge clk);
        #1;
        if (rst) begin
            m_count = 0;
            sb.delete();
            m_err[ERR_OVERFLOW]  = 1'b0;
            m_err[ERR_UNDERFLOW] = 1'b0;
            m_rd_data = '0;
            racc = 1'b0;
        end else begin
            m_count = m_count + int'(wacc) - int'(racc);
            if (clr) begin
                m_err[ERR_OVERFLOW]  = 1'b0;
                m_err[ERR_UNDERFLOW] = 1'b0;
            end
            if (ovf_ev) m_err[ERR_OVERFLOW] = 1'b1;
            if (udf_ev) m_err[ERR_UNDERFLOW] = 1'b1;
        end
`ifdef FIFO_FWFT_EN
        if (racc) void'(sb.pop_front());
        check("rd_valid", rd_valid, m_count != 0);
        m_rd_data = (m_count != 0) ? sb[0] : '0;
        check("rd_data", rd_data, m_rd_data);
`else
        check("rd_valid", rd_valid, racc);
        if (racc) m_rd_data = sb.pop_front();
        check("rd_data", rd_data, m_rd_data);
`endif
        check("count", count, m_count);
        check("full", full, m_count == int'(DEP));
        check("empty", empty, m_count == 0);
        check("almost_full", almost_full, m_count >= int'(af_thresh));
        check("almost_empty", almost_empty, m_count <= int'(ae_thresh));
        check("overflow", overflow, m_err[ERR_OVERFLOW]);
        check("underflow", underflow, m_err[ERR_UNDERFLOW]);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        rd_en     = 1'b0;
        clr_err   = 1'b0;
        af_thresh = 5'd14;
        ae_thresh = 5'd2;

        // Reset with random requests asserted
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_almost_full", almost_full, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_errors", {overflow, underflow}, 0);

        // Fill 0x01..0x10 with threshold edges, then drain in order
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 13) check("af_at_13", almost_full, 0);
            if (i == 14) check("af_at_14", almost_full, 1);
        end
        check("full_at_16", full, 1);
        for (int i = 16; i >= 1; i--) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
            if (i == 16) check("first_read_data", rd_data, 8'h01);
            if (i - 1 == 3) check("ae_at_3", almost_empty, 0);
            if (i - 1 == 2) check("ae_at_2", almost_empty, 1);
        end
        check("last_read_data", rd_data, 8'h10);
        check("empty_after_drain", empty, 1);

        // Underflow, clear, and simultaneous access at empty
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("underflow_set", underflow, 1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("underflow_clr", underflow, 0);
        cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        check("wr_rd_at_empty_count", count, 1);
        check("wr_rd_at_empty_udf", underflow, 1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Overflow: 0xAA must never reach the read side
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        check("overflow_set", overflow, 1);
        check("overflow_count", count, 16);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("overflow_clr", overflow, 0);
        cycle(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1);
        check("clr_vs_set", overflow, 1);
        cycle(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        check("wr_rd_at_full_count", count, 15);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Steady state at count 8 across several pointer wraps
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        check("steady_count", count, 8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("steady_last", rd_data, 8'h80 + 8'd39);

        // Reset mid-operation discards contents and ignores requests
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
        check("midrst_count", count, 0);
        check("midrst_errors", {overflow, underflow}, 0);
        cycle(1'b0, 1'b1, 8'h5C, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("post_rst_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
